// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Instruction-memory loader and store. Assembles a big-endian
//               byte stream from the host into 32-bit words, writes them to
//               a word-addressed instruction memory and holds the CPU fetch
//               stage until a complete program has been written. The fetch
//               stage reads the memory through a combinational port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   load_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    // State encoding
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [AW:0] c_depth   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] c_one     = (AW + 1)'(1);
    localparam logic [1:0]  c_last_by = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [AW:0] r_target;
    logic [AW:0] r_words;
    logic [1:0]  r_cnt;
    // Only the three most recent bytes are needed: the fourth arrives with
    // the write itself.
    logic [23:0] r_asm;
    logic        r_err;

    logic        w_count_ok;
    logic        w_go;
    logic        w_bad;
    logic        w_accept;
    logic        w_word;
    logic        w_last;
    logic [AW:0] w_words_inc;

    // Program store; deliberately not reset, there is no initial image.
    logic [31:0] r_mem [DEPTH];

    assign w_count_ok  = (load_words != '0) && (load_words <= c_depth);
    assign w_accept    = byte_valid && (r_state == c_load);
    assign w_word      = w_accept && (r_cnt == c_last_by);
    assign w_words_inc = r_words + c_one;
    assign w_last      = w_word && (w_words_inc == r_target);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start requests are only honoured outside LOAD
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    if (w_count_ok) begin
                        w_state_nxt = c_load;
                        w_go        = 1'b1;
                    end else begin
                        w_state_nxt = c_idle;
                        w_bad       = 1'b1;
                    end
                end
            end
            c_load: begin
                if (w_last) begin
                    w_state_nxt = c_done;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Load bookkeeping: target latch, byte assembly, word count, error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target <= '0;
            r_words  <= '0;
            r_cnt    <= '0;
            r_asm    <= '0;
            r_err    <= 1'b0;
        end else if (w_go) begin
            r_target <= load_words;
            r_words  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else if (w_bad) begin
            r_err    <= 1'b1;
        end else if (w_accept) begin
            r_asm <= {r_asm[15:0], byte_data};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == c_last_by) begin
                r_words <= w_words_inc;
            end
        end
    end

    // Memory write on the edge that accepts the fourth byte of a word
    always_ff @(posedge clk) begin
        if (w_word) begin
            r_mem[r_words[AW-1:0]] <= {r_asm, byte_data};
        end
    end

    assign fetch_instr  = r_mem[fetch_addr];
    assign byte_ready   = (r_state == c_load);
    assign load_done    = (r_state == c_done);
    assign cpu_hold     = (r_state != c_done);
    assign load_err     = r_err;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Random host words and
//               random stream gaps are checked against a word-level memory
//               model held in plain arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   load_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_instr;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected memory contents and which words are defined
    logic [31:0] exp_mem   [DEPTH];
    bit          exp_known [DEPTH];
    logic [31:0] prog[$];

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_words  (load_words),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is sampled on the following posedge
    task automatic do_start(input int n);
        start      = 1'b1;
        load_words = (AW + 1)'(n);
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Idle cycles with random probability, then one byte for one edge
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit poke_start);
        while ($urandom_range(99) < gap_pct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        chk("byte_ready_in_load", byte_ready, 1'b1);
        byte_valid = 1'b1;
        byte_data  = b;
        if (poke_start) begin
            start      = 1'b1;
            load_words = (AW + 1)'(5);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    // Load the whole of prog, checking each word as soon as it lands
    task automatic load_program(input int gap_pct, input bit midstart);
        int n;
        n = prog.size();
        do_start(n);
        chk("ready_after_start", byte_ready, 1'b1);
        chk("err_clear_on_start", load_err, 1'b0);
        chk("words_cleared", words_loaded, 0);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(prog[w][31-8*b -: 8], gap_pct, midstart && (w == 0) && (b == 2));
            end
            exp_mem[w]   = prog[w];
            exp_known[w] = 1'b1;
            fetch_addr = AW'(w);
            #1;
            chk("word_visible", fetch_instr, prog[w]);
            chk("words_count", words_loaded, w + 1);
            chk("done_timing", load_done, (w == n - 1) ? 1'b1 : 1'b0);
        end
        chk("final_done", load_done, 1'b1);
        chk("final_hold", cpu_hold, 1'b0);
        chk("final_ready", byte_ready, 1'b0);
        chk("final_words", words_loaded, n);
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_known[i]) begin
                fetch_addr = AW'(i);
                #1;
                chk("mem_readback", fetch_instr, exp_mem[i]);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        load_words = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        fetch_addr = '0;

        // Reset state
        #1;
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", load_done, 1'b0);
        chk("rst_err", load_err, 1'b0);
        chk("rst_words", words_loaded, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Bytes offered while idle are refused
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
            chk("idle_ready", byte_ready, 1'b0);
            chk("idle_words", words_loaded, 0);
        end
        byte_valid = 1'b0;

        // Basic load, back-to-back bytes
        prog = '{32'h2008_0005, 32'h2009_0006};
        load_program(0, 1'b0);
        check_mem();

        // Same program with gaps and an ignored mid-load start
        prog = '{32'h2008_0005, 32'h2009_0006};
        load_program(40, 1'b1);
        check_mem();

        // Illegal counts from DONE and from IDLE
        do_start(0);
        chk("ill0_err", load_err, 1'b1);
        chk("ill0_ready", byte_ready, 1'b0);
        chk("ill0_done", load_done, 1'b0);
        chk("ill0_hold", cpu_hold, 1'b1);
        do_start(33);
        chk("ill33_err", load_err, 1'b1);
        chk("ill33_ready", byte_ready, 1'b0);
        chk("ill33_hold", cpu_hold, 1'b1);
        prog = '{$urandom()};
        load_program(20, 1'b0);
        chk("err_after_valid", load_err, 1'b0);

        // Full depth, then a one-word reload touches only word 0
        prog = {};
        for (int i = 0; i < DEPTH; i++) prog.push_back(32'hA000_0000 + i);
        load_program(25, 1'b0);
        check_mem();
        prog = '{32'h1234_5678};
        load_program(0, 1'b0);
        chk("reload_words", words_loaded, 1);
        check_mem();

        // Reset part-way through the second word
        prog = '{$urandom(), $urandom()};
        do_start(2);
        for (int b = 0; b < 4; b++) send_byte(prog[0][31-8*b -: 8], 30, 1'b0);
        send_byte(prog[1][31:24], 30, 1'b0);
        exp_mem[0] = prog[0];
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", byte_ready, 1'b0);
        chk("mid_rst_hold", cpu_hold, 1'b1);
        chk("mid_rst_words", words_loaded, 0);
        @(negedge clk);
        reset = 1'b0;
        check_mem();

        // Fresh load must start at byte 0
        prog = '{$urandom()};
        load_program(0, 1'b0);
        check_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader and store for the legacy MIPS core. It accepts a byte stream from the host/test interface and assembles big-endian 32-bit instruction words. It writes those words into a word-addressed instruction memory, which the fetch stage reads through a combinational port. The fetch stage is held via `cpu_hold` until a complete program has been written.

## Interface
- `DEPTH`, 32: number of 32-bit instruction words.
- `AW`, 5: word-address width; `2**AW == DEPTH`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a load of `load_words` words.
- `load_words` in AW+1: number of words to load; valid range 1..DEPTH.
- `byte_valid` in 1: host byte available.
- `byte_data` in 8: host byte, most-significant byte of each word first.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `fetch_addr` in AW: word address from the fetch stage (PC[AW+1:2]).
- `fetch_instr` out 32: `mem[fetch_addr]`, combinational.
- `cpu_hold` out 1: fetch stage must hold its PC in reset while this is high.
- `load_done` out 1: program loaded; memory stable.
- `load_err` out 1: last start request had an illegal count (sticky).
- `words_loaded` out AW+1: words written in the current or last load.

## Operation
- **States:** IDLE, LOAD, DONE. Reset puts the block in IDLE.
- **Reset values:** `byte_ready`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, `words_loaded`=0, byte counter=0, assembly register=0.
- **Memory reset:** memory contents are NOT reset; there is no initial image.
- **IDLE/DONE + start, 1 ≤ `load_words` ≤ DEPTH:**
  - Go to LOAD.
  - Latch the target count.
  - Clear `words_loaded`, the byte counter and `load_err`.
- **IDLE/DONE + start, `load_words`=0 or > DEPTH:**
  - Go to or stay in IDLE.
  - Set `load_err`=1, `load_done`=0, `cpu_hold`=1.
- **start while in LOAD:** ignored, with no effect on count or state.
- **Byte acceptance:** a byte is accepted on a rising edge with `byte_valid`&`byte_ready`.
  - Each accepted byte shifts into the assembly register (`asm <= {asm[23:0], byte_data}`).
  - The 2-bit byte counter increments.
- **Word write:** on the 4th accepted byte (counter==3), write `{asm[23:0], byte_data}` to `mem[words_loaded[AW-1:0]]` on that same edge.
  - Increment `words_loaded` and wrap the byte counter to 0.
- **End of load:** when the write takes `words_loaded` to the target, go to DONE on that same edge.
- **Outputs by state (decoded, Moore):**
  - `byte_ready` = (state==LOAD).
  - `load_done` = (state==DONE).
  - `cpu_hold` = (state!=DONE).
- **DONE + valid start:** reload. Memory keeps its old words until each is overwritten.
- **Reset mid-load:** returns to IDLE immediately.
  - Partial bytes are discarded.
  - Words already written stay in memory.
  - `cpu_hold`=1.
- **Idle stream:** `byte_valid` while not in LOAD is ignored (`byte_ready`=0).

## Timing
- **Byte latency:** one byte per cycle maximum. Gaps (`byte_valid`=0) are allowed and do not disturb state.
- **Word visibility:** a word is visible on `fetch_instr` from the cycle after the edge that accepted its 4th byte.
- **Completion:** after the edge accepting the final byte:
  - `byte_ready`=0, `load_done`=1 and `cpu_hold`=0 in the next cycle.
  - `words_loaded` = target.
- **start from IDLE:** with a valid start at edge N, `byte_ready`=1 in cycle N+1. The first byte can be accepted at edge N+1.
- **Address range:** `fetch_addr` is always in range; the read has no latency and no enable.
- **Error flag:** `load_err` updates on the start edge and holds until the next valid start or reset.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle.
  - `byte_ready`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0 and `words_loaded`=0 immediately.
  - `byte_valid` pulses are not accepted.
- **Basic load:** start with `load_words`=2, stream 20 08 00 05 20 09 00 06 back-to-back.
  - `mem[0]`=32'h20080005, `mem[1]`=32'h20090006.
  - `load_done`=1 and `cpu_hold`=0 one cycle after the 8th byte; `words_loaded`=2.
- **Backpressure/gaps:** same stream with `byte_valid` low on random cycles, plus a start pulse mid-load.
  - Results are identical to the basic load.
  - The mid-load start is ignored.
- **Illegal counts:** start with `load_words`=0, then with 33.
  - Each time `load_err`=1, state IDLE, `byte_ready`=0.
  - A following valid start with 1 clears `load_err`.
- **Full depth then reload:**
  - Load 32 words `mem[i]` = 32'hA000_0000+i; all 32 read back correctly.
  - From DONE, start with 1 word 32'h12345678: only `mem[0]` changes, `words_loaded`=1.
- **Reset mid-load:** load 2 words, assert reset after 5 bytes.
  - `mem[0]` keeps the new word; `mem[1]` is unchanged.
  - A new load of 1 word starts cleanly at byte 0 (no residue from the 5th byte).
